// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the UART transceiver.
// Parity modes, TX/RX state types and the frame parity function live here.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Callers zero-extend narrower words; extra zeros leave the XOR unchanged.
  function automatic logic parity_of(input logic [8:0] data, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with extra-MSB wrap pointers.
// A read and a write on the same cycle are both honoured even when full.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic             do_rd;
  logic             do_wr;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_xcvr.sv
// Parametrised UART transceiver: private-timer TX, oversampled mid-bit RX
// feeding a FWFT FIFO that carries per-frame parity and framing flags.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned OVS       = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned FIFO_AW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 sout,
  input  logic                 sin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);

  localparam int unsigned BIT_CYC = CLK_DIV * OVS;
  localparam int unsigned TXW     = $clog2(BIT_CYC);
  localparam int unsigned TW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned PW      = $clog2(OVS);

  tx_state_t            tx_state_q, tx_state_d;
  logic [TXW-1:0]       tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_bit_end;

  rx_state_t            rx_state_q, rx_state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [1:0]           sync_q, sync_d;
  logic [PW-1:0]        ph_q, ph_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 tick, s_in, ph_last, ph_mid;
  logic                 fifo_wr, fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS+1:0] fifo_rd_data;

  assign tx_ready   = (tx_state_q == TX_IDLE);
  assign tx_bit_end = (tx_cnt_q == TXW'(BIT_CYC - 1));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      TX_IDLE: if (tx_valid) begin
        tx_state_d = TX_START;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_shift_d = tx_data;
        tx_par_d   = parity_of(9'(tx_data), PARITY);
      end
      TX_START: if (tx_bit_end) tx_state_d = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == 4'(DATA_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit_q == 4'(STOP_BITS - 1)) begin
          tx_bit_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    unique case (tx_state_q)
      TX_START:  sout = 1'b0;
      TX_DATA:   sout = tx_shift_q[0];
      TX_PARITY: sout = tx_par_q;
      default:   sout = 1'b1;
    endcase
  end

  assign tick    = (tick_cnt_q == TW'(CLK_DIV - 1));
  assign s_in    = sync_q[1];
  assign ph_last = (ph_q == PW'(OVS - 1));
  assign ph_mid  = (ph_q == PW'(OVS / 2 - 1));

  // All RX state advances only on tick cycles; the FIFO write lands on the stop-sample tick.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    sync_d     = {sync_q[0], sin};
    rx_state_d = rx_state_q;
    ph_d       = ph_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    fifo_wr    = 1'b0;
    if (tick) begin
      unique case (rx_state_q)
        RX_IDLE: if (!s_in) begin
          rx_state_d = RX_START;
          ph_d       = '0;
          rx_perr_d  = 1'b0;
        end
        RX_START: if (ph_mid) begin
          ph_d       = '0;
          rx_bit_d   = '0;
          rx_state_d = s_in ? RX_IDLE : RX_DATA;
        end else ph_d = ph_q + 1'b1;
        RX_DATA: if (ph_last) begin
          ph_d       = '0;
          rx_shift_d = {s_in, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == 4'(DATA_BITS - 1))
            rx_state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
          else
            rx_bit_d = rx_bit_q + 1'b1;
        end else ph_d = ph_q + 1'b1;
        RX_PARITY: if (ph_last) begin
          ph_d       = '0;
          rx_perr_d  = (s_in != parity_of(9'(rx_shift_q), PARITY));
          rx_state_d = RX_STOP;
        end else ph_d = ph_q + 1'b1;
        RX_STOP: if (ph_last) begin
          ph_d       = '0;
          fifo_wr    = 1'b1;
          rx_state_d = s_in ? RX_IDLE : RX_WAIT_HIGH;
        end else ph_d = ph_q + 1'b1;
        RX_WAIT_HIGH: if (s_in) rx_state_d = RX_IDLE;
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      rx_state_q <= RX_IDLE;
      tick_cnt_q <= '0;
      sync_q     <= '1;
      ph_q       <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      rx_state_q <= rx_state_d;
      tick_cnt_q <= tick_cnt_d;
      sync_q     <= sync_d;
      ph_q       <= ph_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  assign rx_valid   = ~fifo_empty;
  assign fifo_pop   = rx_valid & rx_ready;
  assign rx_overrun = fifo_wr & fifo_full & ~fifo_pop & ~rst;
  assign rx_data    = fifo_rd_data[DATA_BITS+1:2];
  assign rx_perr    = fifo_rd_data[1];
  assign rx_ferr    = fifo_rd_data[0];

  uart_sync_fifo #(
    .WIDTH(DATA_BITS + 2),
    .AW   (FIFO_AW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (fifo_wr),
    .wr_data({rx_shift_q, rx_perr_q, ~s_in}),
    .full   (fifo_full),
    .rd_en  (fifo_pop),
    .rd_data(fifo_rd_data),
    .empty  (fifo_empty)
  );

endmodule
